// File: rtl/status_stack.sv
// Status flag register with a small LIFO save/restore stack for interrupt/call entry and return.
// Define STATUS_STACK_ERR_EN to implement the sticky ovf_err/unf_err bits; otherwise they read 0.
module status_stack #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NFLAGS-1:0]            flags_in,
    input  logic [NFLAGS-1:0]            flag_we,
    input  logic                         sw_we,
    input  logic [NFLAGS-1:0]            sw_data,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         err_clr,
    output logic [NFLAGS-1:0]            flags,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty,
    output logic                         ovf_err,
    output logic                         unf_err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NFLAGS-1:0] flags_reg;
    logic [NFLAGS-1:0] flags_next;
    logic [NFLAGS-1:0] alu_next;
    logic [LW-1:0]     level_reg;
    logic [LW-1:0]     level_next;
    logic [LW-1:0]     level_dec;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [NFLAGS-1:0] slot_mem [DEPTH];

    logic do_push;
    logic do_pop;
    logic ovf_event;
    logic unf_event;

    // A simultaneous push and pop cancels out and is never an error.
    assign do_push   = push & ~pop & ~full;
    assign do_pop    = pop & ~push & ~empty;
    assign ovf_event = push & ~pop & full;
    assign unf_event = pop & ~push & empty;

    assign full      = (level_reg == LW'(DEPTH));
    assign empty     = (level_reg == '0);
    assign level_dec = level_reg - LW'(1);
    assign wr_ptr    = level_reg[AW-1:0];
    assign rd_ptr    = level_dec[AW-1:0];

    generate
        for (genvar gi = 0; gi < NFLAGS; gi++) begin : g_mask
            assign alu_next[gi] = flag_we[gi] ? flags_in[gi] : flags_reg[gi];
        end
    endgenerate

    always_comb begin
        flags_next = alu_next;
        if (do_pop) begin
            flags_next = slot_mem[rd_ptr];
        end else if (sw_we) begin
            flags_next = sw_data;
        end
    end

    always_comb begin
        level_next = level_reg;
        if (do_push) begin
            level_next = level_reg + LW'(1);
        end else if (do_pop) begin
            level_next = level_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= '0;
            level_reg <= '0;
        end else begin
            flags_reg <= flags_next;
            level_reg <= level_next;
        end
    end

    // Slot storage is not reset; the pushed value is the flags before this edge's update.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            slot_mem[wr_ptr] <= flags_reg;
        end
    end

`ifdef STATUS_STACK_ERR_EN
    logic ovf_reg;
    logic unf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_event | (ovf_reg & ~err_clr);
            unf_reg <= unf_event | (unf_reg & ~err_clr);
        end
    end

    assign ovf_err = ovf_reg;
    assign unf_err = unf_reg;
`else
    logic unused_err;
    assign unused_err = err_clr | ovf_event | unf_event;
    assign ovf_err    = 1'b0;
    assign unf_err    = 1'b0;
`endif

    assign flags = flags_reg;
    assign level = level_reg;

endmodule

// File: doc/status_stack.md
STATUS_STACK -- requirements
Module: status_stack

Interface
REQ-001 Parameter NFLAGS, default 4, number of status flags (bit 3=Z, 2=N, 1=V, 0=C at default); legal 1..16.
REQ-002 Parameter DEPTH, default 4, number of save slots in the flag stack; legal 1..16.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port flags_in  input  NFLAGS  new flag values from ALU.
REQ-006 Port flag_we  input  NFLAGS  per-flag write mask for flags_in.
REQ-007 Port sw_we  input  1  software write of whole flag register.
REQ-008 Port sw_data  input  NFLAGS  value for software write.
REQ-009 Port push  input  1  save current flags onto stack (interrupt/call entry).
REQ-010 Port pop  input  1  restore flags from stack top (return).
REQ-011 Port err_clr  input  1  clear sticky error bits.
REQ-012 Port flags  output  NFLAGS  registered current flags.
REQ-013 Port level  output  clog2(DEPTH+1)  number of occupied stack slots.
REQ-014 Port full / empty  output  1 each  level==DEPTH / level==0, combinational from level.
REQ-015 Port ovf_err / unf_err  output  1 each  sticky push-when-full / pop-when-empty flags.

Function
REQ-016 flags update priority per cycle: valid pop restore > sw_we > masked ALU update > hold.
REQ-017 Masked ALU update: flags[i] <= flags_in[i] where flag_we[i]=1, else hold; one-cycle latency, visible on flags the cycle after the edge.
REQ-018 sw_we replaces all NFLAGS bits with sw_data, overriding flag_we for that cycle.
REQ-019 Valid push (push=1, pop=0, not full): slot[level] <= flags value before this edge's update; level+1; flags still take the sw/ALU update the same cycle.
REQ-020 Valid pop (pop=1, push=0, not empty): flags <= slot[level-1]; level-1; sw_we and ALU update that cycle are discarded.
REQ-021 push=1 and pop=1 together: stack and level unchanged, no error, flags follow sw/ALU rules (net no-op on stack).
REQ-022 Push when full: ignored (stack, level unchanged), flags follow sw/ALU rules, ovf_err set.
REQ-023 Pop when empty: ignored, flags follow sw/ALU rules, unf_err set.
REQ-024 Stack is LIFO; pointer never wraps; slots above level hold stale data and are never observable.
REQ-025 err_clr clears ovf_err and unf_err; an error event in the same cycle wins (bit set).

Reset
REQ-026 rst_n low immediately forces flags=0, level=0, ovf_err=0, unf_err=0, independent of clk.
REQ-027 Stack slot contents are not reset; reset mid-push/pop discards the operation.
REQ-028 First edge after rst_n deasserts performs normal operation.

Configuration
REQ-029 Macro STATUS_STACK_ERR_EN: when defined, ovf_err/unf_err are implemented per REQ-022/023/025.
REQ-030 Without STATUS_STACK_ERR_EN: ovf_err and unf_err tied 0, err_clr ignored; overflow/underflow still ignored per REQ-022/023; port list unchanged.

Verification (defaults NFLAGS=4, DEPTH=4, macro defined)
REQ-031 flag_we=4'b0101, flags_in=4'b1111 from flags=0 -> flags=4'b0101 next cycle.
REQ-032 flags=4'b1010, push with flags_in=4'b0110 flag_we=4'hF -> flags=4'b0110, level=1; then pop -> flags=4'b1010, level=0, empty=1.
REQ-033 Five pushes from empty -> level=4, full=1 after fourth, fifth sets ovf_err=1, level stays 4; err_clr -> ovf_err=0.
REQ-034 Pop from empty with sw_we=1, sw_data=4'b1001 -> flags=4'b1001, level=0, unf_err=1.
REQ-035 push=pop=1 at level=2 with flag_we=4'hF, flags_in=4'b0011 -> level=2, flags=4'b0011, no error.
REQ-036 Assert rst_n low between edges at level=3 -> flags, level, errors 0 before next edge; rebuild without macro -> scenario REQ-033 gives ovf_err=0.
